// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns / InvMixColumns / bypass engine.
// Transforms a 128-bit state COLS_PER_CYCLE columns per clock.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready           input handshake
//   in_state, in_mode, in_bypass  state (byte k = bits [8k:8k+7]), 1=inverse, 1=pass-through
//   out_valid/out_ready         output handshake
//   out_state                   result, held stable while out_valid
//   busy                        high while a state is in flight
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic         in_mode,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    localparam int NCYC = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [0:127] data_q, data_d;
    logic [0:127] out_q, out_d;
    logic         mode_q, mode_d;
    logic         byp_q, byp_d;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes: bits [31:24] are row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv && INV_EN) begin
                // 0e, 0b, 0d, 09 built from the xtime chain
                r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                               ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                               ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                               ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                r[31-8*i -: 8] = x2[i]
                               ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                               ^ a[(i+2)%4]
                               ^ a[(i+3)%4];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
            mode_q  <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        out_d   = out_q;
        mode_d  = mode_q;
        byp_d   = byp_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_state;
                    mode_d  = INV_EN ? in_mode : 1'b0;
                    byp_d   = in_bypass;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    out_d[32*(int'(cnt_q)*COLS_PER_CYCLE+j) +: 32] =
                        byp_q ? data_q[32*(int'(cnt_q)*COLS_PER_CYCLE+j) +: 32]
                              : mix_col(data_q[32*(int'(cnt_q)*COLS_PER_CYCLE+j) +: 32], mode_q);
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(NCYC - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
    assign out_state = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: random + directed checks of mix_columns_seq,
// one instance with 1 column/cycle and one with 4 columns/cycle.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [0:127] in_state;
    logic         in_mode;
    logic         in_bypass;
    logic         out_ready;

    logic         ir1, ov1, bz1;
    logic [0:127] os1;
    logic         ir4, ov4, bz4;
    logic [0:127] os4;

    int n_checks = 0;
    int n_err    = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir1),
        .in_state (in_state),
        .in_mode  (in_mode),
        .in_bypass(in_bypass),
        .out_valid(ov1),
        .out_ready(out_ready),
        .out_state(os1),
        .busy     (bz1)
    );

    mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir4),
        .in_state (in_state),
        .in_mode  (in_mode),
        .in_bypass(in_bypass),
        .out_valid(ov4),
        .out_ready(out_ready),
        .out_state(os4),
        .busy     (bz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain GF(2^8) multiply and the circulant matrices.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa ^= 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_mc(input logic [0:127] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [0:127] o;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc ^= gmul(base[(k - r + 4) % 4], s[8*(4*c+k) +: 8]);
                end
                o[8*(4*c+r) +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input string tag, input logic [0:127] st, input logic md,
                       input logic bp, input logic [0:127] exp, output logic [0:127] res);
        int lat1, lat4;
        logic [0:127] r1, r4;
        lat1 = 0;
        lat4 = 0;
        r1   = '0;
        r4   = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_state  = st;
        in_mode   = md;
        in_bypass = bp;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_state  = ~st;
        in_mode   = ~md;
        in_bypass = ~bp;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat1 == 0 && ov1) begin lat1 = k; r1 = os1; end
            if (lat4 == 0 && ov4) begin lat4 = k; r4 = os4; end
        end
        check({tag, " c1 data"}, r1, exp);
        check({tag, " c1 lat"}, 128'(lat1), 128'd4);
        check({tag, " c4 data"}, r4, exp);
        check({tag, " c4 lat"}, 128'(lat4), 128'd1);
        res = r1;
    endtask

    logic [0:127] st, res, res2, snap, exp;
    int waited;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_mode   = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst ov", 128'(ov1), 128'd0);
        check("rst ir", 128'(ir1), 128'd1);
        check("rst busy", 128'(bz1), 128'd0);
        check("rst os", os1, 128'd0);
        check("rst os4", os4, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run("fwd db", 128'hdb135345_db135345_db135345_db135345, 1'b0, 1'b0,
            128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc, res);
        run("fwd fips", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c, res);
        run("inv vec", 128'h8e4da1bc_9fdc589d_8e4da1bc_9fdc589d, 1'b1, 1'b0,
            128'hdb135345_f20a225c_db135345_f20a225c, res);
        run("fix fwd", 128'hc6c6c6c6_01010101_c6c6c6c6_01010101, 1'b0, 1'b0,
            128'hc6c6c6c6_01010101_c6c6c6c6_01010101, res);
        run("fix inv", 128'hc6c6c6c6_01010101_c6c6c6c6_01010101, 1'b1, 1'b0,
            128'hc6c6c6c6_01010101_c6c6c6c6_01010101, res);

        for (int i = 0; i < 6; i++) begin
            st = rnd128();
            run("rnd fwd", st, 1'b0, 1'b0, ref_mc(st, 1'b0), res);
            run("rnd trip", res, 1'b1, 1'b0, st, res2);
            st = rnd128();
            run("rnd inv", st, 1'b1, 1'b0, ref_mc(st, 1'b1), res);
            st = rnd128();
            run("rnd byp", st, i[0], 1'b1, st, res);
        end

        // backpressure
        st  = rnd128();
        exp = ref_mc(st, 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_state  = st;
        in_mode   = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waited = 0;
        while (!ov1 && waited < 12) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("bp ov", 128'(ov1), 128'd1);
        snap = os1;
        check("bp data", snap, exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_state = rnd128();
            in_mode  = 1'b1;
            @(posedge clk);
            #1;
            check("bp hold1", os1, exp);
            check("bp hold4", os4, exp);
            check("bp ir1", 128'(ir1), 128'd0);
            check("bp ir4", 128'(ir4), 128'd0);
            check("bp ov1", 128'(ov1), 128'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp rel ir", 128'(ir1), 128'd1);
        check("bp rel ov", 128'(ov1), 128'd0);
        check("bp rel busy", 128'(bz1), 128'd0);
        check("bp rel ir4", 128'(ir4), 128'd1);
        check("bp rel os", os1, exp);

        // async reset mid-BUSY
        @(negedge clk);
        in_valid  = 1'b1;
        in_state  = rnd128();
        in_mode   = 1'b0;
        in_bypass = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ar pre busy", 128'(bz1), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar ov", 128'(ov1), 128'd0);
        check("ar os", os1, 128'd0);
        check("ar busy", 128'(bz1), 128'd0);
        check("ar ir", 128'(ir1), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        run("ar after", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c, res);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Parametrised, sequential AES MixColumns engine operating on a full 128-bit state (4 columns of 4 bytes).
- Supports forward MixColumns, inverse MixColumns, and a bypass mode for the final cipher round.
- Processes COLS_PER_CYCLE columns per clock with a valid/ready handshake on both sides.
- Sits between the ShiftRows/InvShiftRows and AddRoundKey stages of the round datapath.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- INV_EN, 1, when 0, the inverse datapath is not built, `in_mode` is ignored and forward mode is always used.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input state, mode and bypass are valid.
- in_ready  output  1  block can accept a new state.
- in_state  input  128  state bytes. Ascending index: byte k is bits [8k:8k+7], and bit 8k is the byte MSB. Column c is bytes 4c..4c+3, with byte 4c in row 0.
- in_mode  input  1  0 = forward MixColumns, 1 = inverse.
- in_bypass  input  1  1 = pass the state through unchanged.
- out_valid  output  1  `out_state` holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  transformed state, same byte layout as `in_state`.
- busy  output  1  high in BUSY and DONE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE; the column counter goes to 0.
  - `out_state` = 0, `out_valid` = 0, `in_ready` = 1, `busy` = 0.
  - A partially processed state is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: register `in_state`, `in_mode` (forced to 0 if INV_EN = 0) and `in_bypass`; clear the counter; go to BUSY.
- BUSY:
  - `in_ready` = 0.
  - Each cycle, columns cnt*COLS_PER_CYCLE .. cnt*COLS_PER_CYCLE + COLS_PER_CYCLE - 1 are transformed and written into the matching bytes of the output register; cnt increments.
  - After the cycle handling column 3, go to DONE.
  - Cycles in BUSY = 4/COLS_PER_CYCLE.
- DONE:
  - `out_valid` = 1; `out_state` is stable until the handshake completes.
  - On `out_ready`: go to IDLE.
  - `in_ready` stays 0 in DONE, so there is no same-cycle accept of a new state.
- Latency: accept edge at cycle T gives `out_valid` high from cycle T + 4/COLS_PER_CYCLE. Throughput is one state per 4/COLS_PER_CYCLE + 1 cycles minimum.
- Backpressure: `out_ready` low holds DONE indefinitely with `out_state` unchanged.
- Forward matrix (rows): [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
- Inverse matrix (rows): [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
- Arithmetic in GF(2^8) with reduction polynomial 0x11b:
  - xtime(a) = (a<<1) ^ (a[MSB] ? 0x1b : 0), truncated to 8 bits.
  - Multiples 04 and 08 are chained xtime; all additions are XOR.
- Bypass: output = captured input bytes, with the same BUSY/DONE timing as a real transform (constant latency regardless of mode).
- Mode and bypass are sampled only at the accept edge. Changes to them during BUSY or DONE have no effect.
- `in_state` changes after the accept edge have no effect; the input is fully registered.

Test Plan:
- Forward, COLS_PER_CYCLE=1: every column = db 13 53 45 → every output column = 8e 4d a1 bc.
  - `out_valid` rises exactly 4 cycles after accept.
- Forward, COLS_PER_CYCLE=4: columns d4 bf 5d 30 / e0 b4 52 ae / b8 41 11 f1 / 1e 27 98 e5 → 04 66 81 e5 / e0 cb 19 9a / 48 f8 d3 7a / 28 06 26 4c.
  - Latency is 1 cycle.
- Inverse: 8e 4d a1 bc → db 13 53 45, and 9f dc 58 9d → f2 0a 22 5c.
  - Round trip (forward then inverse) of random states returns the original state.
- Invariants and bypass:
  - c6 c6 c6 c6 and 01 01 01 01 map to themselves in both modes.
  - Bypass=1 with any state → identical output after the full latency.
- Backpressure and handshake: hold `out_ready` = 0 for 10 cycles.
  - `out_state` is stable; `in_ready` stays 0; `in_valid` pulses in that window are not accepted.
  - `out_ready` = 1 → IDLE next cycle.
- Asynchronous reset: assert `rst` mid-BUSY with COLS_PER_CYCLE = 1.
  - `out_valid`, `out_state` and `busy` go to 0 immediately; `in_ready` goes to 1.
  - The next accepted state produces a correct result.
